// File: rtl/uart_tx_frame_engine.sv
// uart_tx_frame_engine
//   Parametrised UART transmitter with a built-in baud counter. Each word
//   accepted on the valid/ready handshake is sent as:
//     start (low), DATA_BITS data bits LSB first, optional parity, STOP_BITS stop (high).
//   Every serial bit lasts exactly CLKS_PER_BIT clk cycles.
//
// Parameters
//   CLKS_PER_BIT  clk cycles per serial bit (>= 2)
//   DATA_BITS     data bits per frame (5..9)
//   PARITY        0 = none, 1 = odd, 2 = even
//   STOP_BITS     stop bits per frame (1 or 2)
//
// Ports
//   clk         system clock, rising edge
//   reset       synchronous, active-high reset
//   tx_data     word to send, sampled only on accept
//   tx_valid    source presents a word on tx_data
//   tx_ready    high only while idle; accept = tx_valid & tx_ready
//   tx          registered serial output, idle high
//   busy        high from the cycle after accept until the frame ends
//   frame_done  one-cycle pulse in the first idle cycle after a complete frame

module uart_tx_frame_engine #(
    parameter int CLKS_PER_BIT = 434,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 tx,
    output logic                 busy,
    output logic                 frame_done
);

    generate
        if (CLKS_PER_BIT < 2) begin : g_bad_clks_per_bit
            $error("uart_tx_frame_engine: CLKS_PER_BIT must be >= 2");
        end
        if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
            $error("uart_tx_frame_engine: DATA_BITS must be in 5..9");
        end
        if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
            $error("uart_tx_frame_engine: PARITY must be 0, 1 or 2");
        end
        if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
            $error("uart_tx_frame_engine: STOP_BITS must be 1 or 2");
        end
    endgenerate

    localparam int BAUD_W = $clog2(CLKS_PER_BIT);
    localparam int BIT_W  = $clog2(DATA_BITS) + 1;

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(DATA_BITS - 1);
    localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t               state, state_next;
    logic [BAUD_W-1:0]    baud_cnt, baud_cnt_next;
    logic [BIT_W-1:0]     bit_cnt, bit_cnt_next;     // data bit index, reused as stop-bit index
    logic [DATA_BITS-1:0] shift_reg, shift_reg_next;
    logic                 parity_bit, parity_bit_next;
    logic                 tx_next;
    logic                 frame_done_next;
    logic                 bit_end;

    // Last clk cycle of the current serial bit.
    assign bit_end  = (baud_cnt == BAUD_LAST);
    assign tx_ready = (state == S_IDLE);
    assign busy     = (state != S_IDLE);

    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            baud_cnt   <= '0;
            bit_cnt    <= '0;
            shift_reg  <= '0;
            parity_bit <= 1'b0;
            tx         <= 1'b1;
            frame_done <= 1'b0;
        end else begin
            state      <= state_next;
            baud_cnt   <= baud_cnt_next;
            bit_cnt    <= bit_cnt_next;
            shift_reg  <= shift_reg_next;
            parity_bit <= parity_bit_next;
            tx         <= tx_next;
            frame_done <= frame_done_next;
        end
    end

    // tx is computed one cycle ahead and registered, so it only moves on a
    // bit boundary (or reset) and never glitches.
    always_comb begin
        // NOTE: every output of this block gets a default first; a path that
        // leaves one unassigned would infer a latch.
        state_next      = state;
        baud_cnt_next   = baud_cnt;
        bit_cnt_next    = bit_cnt;
        shift_reg_next  = shift_reg;
        parity_bit_next = parity_bit;
        tx_next         = tx;
        frame_done_next = 1'b0;

        if (state != S_IDLE) begin
            baud_cnt_next = bit_end ? '0 : baud_cnt + BAUD_W'(1);
        end

        case (state)
            S_IDLE: begin
                baud_cnt_next = '0;
                bit_cnt_next  = '0;
                tx_next       = 1'b1;
                if (tx_valid) begin
                    shift_reg_next  = tx_data;
                    // Odd: complement of the data's XOR; even: the XOR itself.
                    parity_bit_next = (PARITY == 1) ? ~^tx_data : ^tx_data;
                    tx_next         = 1'b0;
                    state_next      = S_START;
                end
            end

            S_START: begin
                if (bit_end) begin
                    tx_next        = shift_reg[0];
                    shift_reg_next = shift_reg >> 1;
                    bit_cnt_next   = '0;
                    state_next     = S_DATA;
                end
            end

            S_DATA: begin
                if (bit_end) begin
                    if (bit_cnt == DATA_LAST) begin
                        bit_cnt_next = '0;
                        if (PARITY != 0) begin
                            tx_next    = parity_bit;
                            state_next = S_PARITY;
                        end else begin
                            tx_next    = 1'b1;
                            state_next = S_STOP;
                        end
                    end else begin
                        tx_next        = shift_reg[0];
                        shift_reg_next = shift_reg >> 1;
                        bit_cnt_next   = bit_cnt + BIT_W'(1);
                    end
                end
            end

            S_PARITY: begin
                if (bit_end) begin
                    tx_next    = 1'b1;
                    state_next = S_STOP;
                end
            end

            S_STOP: begin
                if (bit_end) begin
                    if (bit_cnt == STOP_LAST) begin
                        frame_done_next = 1'b1;
                        state_next      = S_IDLE;
                    end else begin
                        bit_cnt_next = bit_cnt + BIT_W'(1);
                    end
                end
            end

            default: begin
                tx_next    = 1'b1;
                state_next = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_tx_frame_engine.sv
// tb_uart_tx_frame_engine
//   Four transmitter configurations side by side:
//     dut0: 8N1, 4 clk/bit     dut1: 8E1, 4 clk/bit
//     dut2: 8O1, 2 clk/bit     dut3: 7N2, 3 clk/bit
//   Observed vector per cycle is {tx, busy, tx_ready, frame_done}.

module tb_uart_tx_frame_engine;

    logic             clk;
    logic             reset;
    logic [3:0]       tx_valid;
    logic [3:0][7:0]  tx_data;
    wire  [3:0]       tx_w;
    wire  [3:0]       busy_w;
    wire  [3:0]       tx_ready_w;
    wire  [3:0]       done_w;

    int n_pass  = 0;
    int n_total = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    uart_tx_frame_engine #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) dut0 (
        .clk(clk), .reset(reset), .tx_data(tx_data[0]), .tx_valid(tx_valid[0]),
        .tx_ready(tx_ready_w[0]), .tx(tx_w[0]), .busy(busy_w[0]), .frame_done(done_w[0]));

    uart_tx_frame_engine #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) dut1 (
        .clk(clk), .reset(reset), .tx_data(tx_data[1]), .tx_valid(tx_valid[1]),
        .tx_ready(tx_ready_w[1]), .tx(tx_w[1]), .busy(busy_w[1]), .frame_done(done_w[1]));

    uart_tx_frame_engine #(.CLKS_PER_BIT(2), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) dut2 (
        .clk(clk), .reset(reset), .tx_data(tx_data[2]), .tx_valid(tx_valid[2]),
        .tx_ready(tx_ready_w[2]), .tx(tx_w[2]), .busy(busy_w[2]), .frame_done(done_w[2]));

    uart_tx_frame_engine #(.CLKS_PER_BIT(3), .DATA_BITS(7), .PARITY(0), .STOP_BITS(2)) dut3 (
        .clk(clk), .reset(reset), .tx_data(tx_data[3][6:0]), .tx_valid(tx_valid[3]),
        .tx_ready(tx_ready_w[3]), .tx(tx_w[3]), .busy(busy_w[3]), .frame_done(done_w[3]));

    // ---------------- configuration of each instance ----------------
    function automatic int cpb_of(input int d);
        case (d)
            0, 1:    return 4;
            2:       return 2;
            default: return 3;
        endcase
    endfunction

    function automatic int db_of(input int d);
        return (d == 3) ? 7 : 8;
    endfunction

    function automatic int par_of(input int d);
        case (d)
            1:       return 2;
            2:       return 1;
            default: return 0;
        endcase
    endfunction

    function automatic int sb_of(input int d);
        return (d == 3) ? 2 : 1;
    endfunction

    function automatic int flen_of(input int d);
        return 1 + db_of(d) + ((par_of(d) != 0) ? 1 : 0) + sb_of(d);
    endfunction

    // Reference frame: bit i of the result is the i-th bit on the line.
    function automatic logic [11:0] model_frame(input int d, input logic [7:0] data);
        logic [11:0] f;
        int          idx;
        int          ones;
        f    = '0;
        idx  = 1;            // f[0] is the start bit, low
        ones = 0;
        for (int i = 0; i < db_of(d); i++) begin
            f[idx] = data[i];
            if (data[i]) ones++;
            idx++;
        end
        if (par_of(d) == 1) begin
            f[idx] = ((ones % 2) == 0);   // make the total count odd
            idx++;
        end else if (par_of(d) == 2) begin
            f[idx] = ((ones % 2) == 1);   // make the total count even
            idx++;
        end
        for (int s = 0; s < sb_of(d); s++) begin
            f[idx] = 1'b1;
            idx++;
        end
        return f;
    endfunction

    function automatic logic [3:0] obs(input int d);
        return {tx_w[d], busy_w[d], tx_ready_w[d], done_w[d]};
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h required %0h", name, got, exp);
    endtask

    // Wait one cycle, confirm idle, and present a word for accept.
    task automatic start_frame(input int d, input logic [7:0] data);
        @(negedge clk);
        check($sformatf("idle_before d%0d", d), {28'd0, obs(d)}, 32'hA);
        tx_data[d]  = data;
        tx_valid[d] = 1'b1;
    endtask

    // Follows one frame from the accept edge through the first idle cycle.
    // keep_valid: hold tx_valid and switch to next_data for a back-to-back accept.
    // disturb: scramble tx_data / tx_valid while the frame is in flight.
    task automatic check_frame(input int d, input logic [11:0] exp_f, input string tag,
                               input bit keep_valid, input logic [7:0] next_data,
                               input bit disturb);
        int cpb;
        int n;
        cpb = cpb_of(d);
        n   = flen_of(d) * cpb;
        @(posedge clk);
        for (int c = 1; c <= n + 1; c++) begin
            @(negedge clk);
            if (c <= n)
                check($sformatf("%s d%0d cyc%0d", tag, d, c), {28'd0, obs(d)},
                      {28'd0, exp_f[(c - 1) / cpb], 3'b100});
            else
                check($sformatf("%s d%0d end cyc%0d", tag, d, c), {28'd0, obs(d)}, 32'hB);
            if (c == 1) begin
                if (keep_valid) tx_data[d] = next_data;
                else            tx_valid[d] = 1'b0;
            end
            if (disturb && c <= n) begin
                tx_valid[d] = 1'($urandom_range(0, 1));
                tx_data[d]  = 8'($urandom);
            end
            if (c == n + 1 && !keep_valid) tx_valid[d] = 1'b0;
        end
    endtask

    typedef struct {
        int          dut;
        logic [7:0]  data;
        logic [11:0] frame;
        string       tag;
    } vec_t;

    vec_t vecs [12];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit         seen_done;
        int         d;
        logic [7:0] data;
        bit         dis;

        // Hand-derived frames: {stop(s), [parity], data, start}.
        vecs[0]  = '{0, 8'hA5, 12'({1'b1, 8'hA5, 1'b0}),        "t1_8n1_a5"};
        vecs[1]  = '{0, 8'h00, 12'({1'b1, 8'h00, 1'b0}),        "8n1_00"};
        vecs[2]  = '{0, 8'hFF, 12'({1'b1, 8'hFF, 1'b0}),        "8n1_ff"};
        vecs[3]  = '{1, 8'h07, 12'({1'b1, 1'b1, 8'h07, 1'b0}),  "t2_even_07"};
        vecs[4]  = '{2, 8'h07, 12'({1'b1, 1'b0, 8'h07, 1'b0}),  "t2_odd_07"};
        vecs[5]  = '{1, 8'h00, 12'({1'b1, 1'b0, 8'h00, 1'b0}),  "even_00"};
        vecs[6]  = '{1, 8'hFF, 12'({1'b1, 1'b0, 8'hFF, 1'b0}),  "even_ff"};
        vecs[7]  = '{2, 8'h00, 12'({1'b1, 1'b1, 8'h00, 1'b0}),  "odd_00"};
        vecs[8]  = '{2, 8'h80, 12'({1'b1, 1'b0, 8'h80, 1'b0}),  "odd_80"};
        vecs[9]  = '{3, 8'h55, 12'({2'b11, 7'h55, 1'b0}),       "t5_7n2_55"};
        vecs[10] = '{3, 8'h7F, 12'({2'b11, 7'h7F, 1'b0}),       "7n2_7f"};
        vecs[11] = '{3, 8'h2A, 12'({2'b11, 7'h2A, 1'b0}),       "7n2_2a"};

        tx_valid = '0;
        tx_data  = '0;
        reset    = 1'b1;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 4; i++)
            check($sformatf("reset_values d%0d", i), {28'd0, obs(i)}, 32'hA);
        reset = 1'b0;

        // Table-driven frames.
        for (int i = 0; i < 12; i++) begin
            start_frame(vecs[i].dut, vecs[i].data);
            check_frame(vecs[i].dut, vecs[i].frame, vecs[i].tag, 1'b0, 8'h00, 1'b0);
        end

        // Back-to-back with tx_valid held: single idle-high cycle between frames.
        start_frame(0, 8'h11);
        check_frame(0, 12'({1'b1, 8'h11, 1'b0}), "t3_first", 1'b1, 8'h22, 1'b0);
        check_frame(0, 12'({1'b1, 8'h22, 1'b0}), "t3_second", 1'b0, 8'h00, 1'b0);

        // Reset during data bit 3 (frame bit 4 = cycles 17..20 at 4 clk/bit).
        start_frame(0, 8'hA5);
        @(posedge clk);
        for (int c = 1; c <= 18; c++) begin
            @(negedge clk);
            check($sformatf("t4_pre d0 cyc%0d", c), {28'd0, obs(0)},
                  {28'd0, vecs[0].frame[(c - 1) / 4], 3'b100});
            if (c == 1) tx_valid[0] = 1'b0;
        end
        reset = 1'b1;
        @(negedge clk);
        check("t4_abort_state", {28'd0, obs(0)}, 32'hA);
        reset = 1'b0;
        seen_done = 1'b0;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (done_w[0]) seen_done = 1'b1;
        end
        check("t4_no_frame_done", {31'd0, seen_done}, 32'd0);
        start_frame(0, 8'h3C);
        check_frame(0, 12'({1'b1, 8'h3C, 1'b0}), "t4_after", 1'b0, 8'h00, 1'b0);

        // Input activity while busy must not touch the frame in flight.
        start_frame(1, 8'hC3);
        check_frame(1, 12'({1'b1, 1'b0, 8'hC3, 1'b0}), "t6_even_c3", 1'b0, 8'h00, 1'b1);
        start_frame(3, 8'h33);
        check_frame(3, 12'({2'b11, 7'h33, 1'b0}), "t6_7n2_33", 1'b0, 8'h00, 1'b1);

        // Randomised frames against the reference model.
        for (int k = 0; k < 40; k++) begin
            d    = int'($urandom_range(0, 3));
            data = 8'($urandom);
            dis  = 1'($urandom_range(0, 1));
            start_frame(d, data);
            check_frame(d, model_frame(d, data), $sformatf("rand%0d", k), 1'b0, 8'h00, dis);
        end
        @(negedge clk);
        for (int i = 0; i < 4; i++)
            check($sformatf("final_idle d%0d", i), {28'd0, obs(i)}, 32'hA);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
